ctrl_step_sequencer: RTL

//  Parametrised multicycle control-step generator for the datapath; replaces hand-driven T0..Tn benches.

---
 rtl/css_pkg.sv | 37 +++
 rtl/css_decode.sv | 45 ++++
 rtl/ctrl_step_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/css_pkg.sv
// css_pkg: shared definitions for the multicycle control-step sequencer.
//   - IR opcode encodings (5-bit field IR[31:27])
//   - ALU select codes driven on Alu_op
//   - sequencer state and instruction-class enums
package css_pkg;

  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MFHI = 5'b10100;
  localparam logic [4:0] OP_MFLO = 5'b10101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_AND = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;

  // Step index of the first execute step; T0..T2 are the shared fetch.
  localparam int EXEC_FIRST = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CL_MFHI    = 3'd0,
    CL_MFLO    = 3'd1,
    CL_NOP     = 3'd2,
    CL_HALT    = 3'd3,
    CL_ALU     = 3'd4,
    CL_ILLEGAL = 3'd5
  } class_e;

endpackage

// File: rtl/css_decode.sv
// css_decode: purely combinational opcode decoder for the step sequencer.
// Ports:
//   opcode    in   OPCODE_W  latched IR opcode
//   op_class  out  class_e   instruction class
//   alu_op    out  4         ALU select for immediate ALU ops (ADD otherwise)
//   last_step out  4         step index on which the instruction completes
module css_decode
  import css_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output class_e              op_class,
  output logic [3:0]          alu_op,
  output logic [3:0]          last_step
);

  always_comb begin
    op_class  = CL_ILLEGAL;
    alu_op    = ALU_ADD;
    last_step = 4'(EXEC_FIRST);
    if (opcode == OPCODE_W'(OP_ADDI)) begin
      op_class  = CL_ALU;
      alu_op    = ALU_ADD;
      last_step = 4'(EXEC_FIRST + 2);
    end else if (opcode == OPCODE_W'(OP_ANDI)) begin
      op_class  = CL_ALU;
      alu_op    = ALU_AND;
      last_step = 4'(EXEC_FIRST + 2);
    end else if (opcode == OPCODE_W'(OP_ORI)) begin
      op_class  = CL_ALU;
      alu_op    = ALU_OR;
      last_step = 4'(EXEC_FIRST + 2);
    end else if (opcode == OPCODE_W'(OP_MFHI)) begin
      op_class = CL_MFHI;
    end else if (opcode == OPCODE_W'(OP_MFLO)) begin
      op_class = CL_MFLO;
    end else if (opcode == OPCODE_W'(OP_NOP)) begin
      op_class = CL_NOP;
    end else if (opcode == OPCODE_W'(OP_HALT)) begin
      op_class = CL_HALT;
    end
  end

endmodule

// File: rtl/ctrl_step_sequencer.sv
// ctrl_step_sequencer: multicycle control-step generator. Runs the shared
// fetch (T0-T2), latches the IR opcode entering T3, then drives the execute
// strobes for MFHI/MFLO/ADDI/ANDI/ORI/NOP/HALT and loops back to fetch.
// Optional feature macro: CSS_MEM_WAIT_EN (adds Mem_ready; T1 stalls on it).
// Ports:
//   Clock, Clear(async active-low), Run, Opcode[OPCODE_W], Mem_ready (optional)
//   Step[NUM_STEPS]   one-hot T-step, zero in IDLE/HALTED
//   fetch strobes     PCout MARin IncPC PCin Read MDRin MDRout IRin
//   execute strobes   Gra Grb Rin Rout HIout LOout Yin Cout ZLowin ZLowout
//   Alu_op[4], Done (pulse), Halted (level), Illegal (pulse), Instr_count[CNT_W]
module ctrl_step_sequencer
  import css_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int OPCODE_W  = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 Clock,
  input  logic                 Clear,
  input  logic                 Run,
  input  logic [OPCODE_W-1:0]  Opcode,
`ifdef CSS_MEM_WAIT_EN
  input  logic                 Mem_ready,
`endif
  output logic [NUM_STEPS-1:0] Step,
  output logic                 PCout,
  output logic                 MARin,
  output logic                 IncPC,
  output logic                 PCin,
  output logic                 Read,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 Gra,
  output logic                 Grb,
  output logic                 Rin,
  output logic                 Rout,
  output logic                 HIout,
  output logic                 LOout,
  output logic                 Yin,
  output logic                 Cout,
  output logic                 ZLowin,
  output logic                 ZLowout,
  output logic [3:0]           Alu_op,
  output logic                 Done,
  output logic                 Halted,
  output logic                 Illegal,
  output logic [CNT_W-1:0]     Instr_count
);

  localparam int K_W = $clog2(NUM_STEPS);

  generate
    if (NUM_STEPS < 6 || NUM_STEPS > 16) begin : g_bad_num_steps
      $error("ctrl_step_sequencer: NUM_STEPS must be in 6..16");
    end
  endgenerate

  state_e              state, state_nxt;
  logic [K_W-1:0]      k, k_nxt;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    cnt;
  class_e              op_class;
  logic [3:0]          dec_alu;
  logic [3:0]          dec_last;
  logic                in_step;
  logic                done;
  logic                illegal;
  logic                t1_go;

  css_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode   (op_q),
    .op_class (op_class),
    .alu_op   (dec_alu),
    .last_step(dec_last)
  );

`ifdef CSS_MEM_WAIT_EN
  assign t1_go = Mem_ready;
`else
  assign t1_go = 1'b1;
`endif

  assign in_step = (state == ST_STEP);

  // Completion and fault are only meaningful once the opcode has been latched.
  // Hitting the last step slot without completing is treated as an illegal
  // instruction so the counter can never run past NUM_STEPS-1.
  assign done    = in_step && (int'(k) >= EXEC_FIRST) && (op_class != CL_ILLEGAL) &&
                   (int'(k) == int'(dec_last));
  assign illegal = in_step && !done &&
                   (((int'(k) == EXEC_FIRST) && (op_class == CL_ILLEGAL)) ||
                    (int'(k) == NUM_STEPS - 1));

  // Stage: state register
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state <= ST_IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // T2 always advances to T3, so capturing here is the opcode seen entering T3.
  always_ff @(posedge Clock) begin
    if (in_step && (int'(k) == EXEC_FIRST - 1)) begin
      op_q <= Opcode;
    end
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      cnt <= '0;
    end else if (done) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin : next_state
    state_nxt = state;
    k_nxt     = k;
    case (state)
      ST_IDLE: begin
        if (Run) begin
          state_nxt = ST_STEP;
          k_nxt     = '0;
        end
      end
      ST_STEP: begin
        if (done && (op_class == CL_HALT)) begin
          state_nxt = ST_HALTED;
          k_nxt     = '0;
        end else if (done || illegal) begin
          // Back-to-back fetch when Run is still high, no idle bubble.
          state_nxt = Run ? ST_STEP : ST_IDLE;
          k_nxt     = '0;
        end else if ((int'(k) == 1) && !t1_go) begin
          k_nxt = k;
        end else begin
          k_nxt = k + K_W'(1);
        end
      end
      ST_HALTED: begin
        state_nxt = ST_HALTED;
        k_nxt     = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        k_nxt     = '0;
      end
    endcase
  end

  always_comb begin : outputs
    Step    = '0;
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    HIout   = 1'b0;
    LOout   = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    ZLowin  = 1'b0;
    ZLowout = 1'b0;
    Alu_op  = ALU_ADD;
    if (in_step) begin
      Step = NUM_STEPS'(1) << k;
      if (int'(k) == 0) begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        ZLowin = 1'b1;
      end else if (int'(k) == 1) begin
        ZLowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end else if (int'(k) == 2) begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end else if (int'(k) == EXEC_FIRST) begin
        case (op_class)
          CL_MFHI: begin
            Gra   = 1'b1;
            Rin   = 1'b1;
            HIout = 1'b1;
          end
          CL_MFLO: begin
            Gra   = 1'b1;
            Rin   = 1'b1;
            LOout = 1'b1;
          end
          CL_ALU: begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
          end
          default: begin
          end
        endcase
      end else if ((int'(k) == EXEC_FIRST + 1) && (op_class == CL_ALU)) begin
        Cout   = 1'b1;
        ZLowin = 1'b1;
        Alu_op = dec_alu;
      end else if ((int'(k) == EXEC_FIRST + 2) && (op_class == CL_ALU)) begin
        ZLowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
      end
    end
  end

  assign Done        = done;
  assign Illegal     = illegal;
  assign Halted      = (state == ST_HALTED) || (done && (op_class == CL_HALT));
  assign Instr_count = cnt;

endmodule
